// File: rtl/prog_loader_rx_pkg.sv
// Shared widths, state encodings and helpers for the UART program loader.
package prog_loader_rx_pkg;

   localparam int DATA_LEN = 32;
   localparam int INSN_LEN = 32;
   localparam int LINE_LEN = 4 * INSN_LEN;
   localparam int LANES    = LINE_LEN / DATA_LEN;
   localparam int LANE_W   = $clog2(LANES);

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_BITS,
      RX_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      S_LEN,
      S_DATA,
      S_FLUSH,
      S_SUM,
      S_DONE
   } ld_state_t;

   // Headers beyond the memory image size are treated as a full image.
   function automatic logic [31:0] clamp_words(input logic [31:0] hdr,
                                               input logic [31:0] max_words);
      return (hdr > max_words) ? max_words : hdr;
   endfunction

endpackage

// File: rtl/prog_loader_rx_if.sv
// Loader-to-memory write bus: word/line data, byte address and write strobes.
interface prog_loader_rx_if
   import prog_loader_rx_pkg::*;
#(
   parameter int ADDR_LEN = 32
);
   logic [ADDR_LEN-1:0] addr;
   logic [LINE_LEN-1:0] data;
   logic                we_32;
   logic                we_128;

   modport master (output addr, data, we_32, we_128);
   modport slave  (input  addr, data, we_32, we_128);
endinterface

// File: rtl/prog_loader_rx_uart_rx_byte.sv
// 8N1 UART byte receiver with input synchronizer, glitch rejection and
// a sticky framing-error flag.
module uart_rx_byte
   import prog_loader_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   rx_state_t        state;
   logic             rxd_meta;
   logic             rxd_sync;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             wait_high;

   // After a bad stop bit the line must return high before a new start bit
   // can be recognised, otherwise a held-low line would retrigger forever.
   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_meta   <= 1'b1;
         rxd_sync   <= 1'b1;
         state      <= RX_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         wait_high  <= 1'b0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         frame_err  <= 1'b0;
      end else begin
         rxd_meta   <= rxd;
         rxd_sync   <= rxd_meta;
         byte_valid <= 1'b0;
         case (state)
            RX_IDLE: begin
               cnt <= '0;
               if (!rxd_sync) state <= RX_START;
            end
            RX_START: begin
               if (cnt == HALF_M1) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rxd_sync ? RX_IDLE : RX_BITS;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_BITS: begin
               if (cnt == FULL_M1) begin
                  cnt     <= '0;
                  shreg   <= {rxd_sync, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= RX_STOP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (wait_high) begin
                  if (rxd_sync) begin
                     wait_high <= 1'b0;
                     state     <= RX_IDLE;
                  end
               end else if (cnt == FULL_M1) begin
                  cnt <= '0;
                  if (rxd_sync) begin
                     byte_valid <= 1'b1;
                     byte_data  <= shreg;
                     state      <= RX_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     wait_high <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/prog_loader_rx.sv
// UART program loader: length header, then little-endian words written to dmem
// (per word) and imem (per 128-bit line). Define PLOADER_CHECKSUM_EN to expect
// a trailing 32-bit sum word and report mismatches on cksum_err.
module prog_loader_rx
   import prog_loader_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_LEN     = 32,
   parameter int MAX_WORDS    = 2048
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rxd,
   prog_loader_rx_if.master bus,
   output logic             done,
   output logic             busy,
   output logic             frame_err,
   output logic             cksum_err
);

   localparam int CNT_W = $clog2(MAX_WORDS + 1);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   logic                byte_valid;
   logic [7:0]          byte_data;
   ld_state_t           state;
   logic [1:0]          byte_cnt;
   logic [23:0]         byte_acc;
   logic [LANE_W-1:0]   lane;
   logic [CNT_W-1:0]    word_cnt;
   logic [CNT_W-1:0]    n_words;
   logic [ADDR_LEN-1:0] addr_q;
   logic [LINE_LEN-1:0] data_q;
   logic                we_32_q;
   logic                we_128_q;
   logic [31:0]         word;
   logic                word_done;

`ifdef PLOADER_CHECKSUM_EN
   logic [DATA_LEN-1:0] sum_q;
   logic                cksum_q;
   assign cksum_err = cksum_q;
   localparam ld_state_t END_STATE = S_SUM;
`else
   assign cksum_err = 1'b0;
   localparam ld_state_t END_STATE = S_DONE;
`endif
   localparam logic END_IS_DONE = (END_STATE == S_DONE);

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .frame_err (frame_err)
   );

   assign word      = {byte_data, byte_acc};
   assign word_done = byte_valid && (byte_cnt == 2'd3) && (state != S_DONE);

   assign bus.addr   = addr_q;
   assign bus.data   = data_q;
   assign bus.we_32  = we_32_q;
   assign bus.we_128 = we_128_q;

   // New words enter at the top lane so data[127:96] is always the word being
   // written; a partial final line is shifted down with zeros before its imem write.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_LEN;
         byte_cnt <= '0;
         byte_acc <= '0;
         lane     <= '0;
         word_cnt <= '0;
         n_words  <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         we_32_q  <= 1'b0;
         we_128_q <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
`ifdef PLOADER_CHECKSUM_EN
         sum_q    <= '0;
         cksum_q  <= 1'b0;
`endif
      end else begin
         we_32_q  <= 1'b0;
         we_128_q <= 1'b0;
         if (byte_valid && state != S_DONE) begin
            byte_cnt <= byte_cnt + 2'd1;
            byte_acc <= {byte_data, byte_acc[23:8]};
         end
         case (state)
            S_LEN: begin
               if (byte_valid) busy <= 1'b1;
               if (word_done) begin
                  n_words  <= CNT_W'(clamp_words(word, 32'(MAX_WORDS)));
                  word_cnt <= '0;
                  lane     <= '0;
                  if (word == 32'd0) begin
                     state <= END_STATE;
                     done  <= END_IS_DONE;
                     busy  <= !END_IS_DONE;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (word_done) begin
                  data_q   <= {word, data_q[LINE_LEN-1:DATA_LEN]};
                  addr_q   <= ADDR_LEN'({word_cnt, 2'b00});
                  we_32_q  <= 1'b1;
                  we_128_q <= (lane == LAST_LANE);
                  lane     <= lane + LANE_W'(1);
                  word_cnt <= word_cnt + CNT_W'(1);
`ifdef PLOADER_CHECKSUM_EN
                  sum_q    <= sum_q + word;
`endif
                  if (word_cnt == n_words - CNT_W'(1)) begin
                     if (lane != LAST_LANE) begin
                        state <= S_FLUSH;
                     end else begin
                        state <= END_STATE;
                        done  <= END_IS_DONE;
                        busy  <= !END_IS_DONE;
                     end
                  end
               end
            end
            S_FLUSH: begin
               data_q <= {DATA_LEN'(0), data_q[LINE_LEN-1:DATA_LEN]};
               addr_q <= addr_q + ADDR_LEN'(4);
               lane   <= lane + LANE_W'(1);
               if (lane == LAST_LANE) begin
                  we_128_q <= 1'b1;
                  state    <= END_STATE;
                  done     <= END_IS_DONE;
                  busy     <= !END_IS_DONE;
               end
            end
`ifdef PLOADER_CHECKSUM_EN
            S_SUM: begin
               if (word_done) begin
                  cksum_q <= cksum_q | (word != sum_q);
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= S_DONE;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
